// File: rtl/segment_if.sv
// Display-bus bundle between a 7-segment pattern source and the segment decoder/monitor.
// The source drives the active-low pattern and the decoder returns its decoded status.
interface segment_if #(
    parameter int ERR_W = 8
);
    logic [6:0]       segment;
    logic [3:0]       digit;
    logic             digit_valid;
    logic             blank;
    logic             invalid;
    logic             seq_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output segment,
        input  digit, digit_valid, blank, invalid, seq_err, err_count
    );

    modport slave (
        input  segment,
        output digit, digit_valid, blank, invalid, seq_err, err_count
    );
endinterface

// File: rtl/segment_decoder.sv
// Seven-segment bus monitor: debounces the active-low pattern, decodes it to BCD,
// and flags undecodable patterns and digits that do not advance by +1 mod 10.
module segment_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic     clk,
    input  logic     rst,
    segment_if.slave bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [6:0]       PAT_BLANK  = 7'b1111111;
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

    typedef enum logic [0:0] {IDLE = 1'b0, TRACK = 1'b1} state_t;

    // Returns {is_digit, bcd}; is_digit is low for blank and every undecodable code.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        case (pat)
            7'b0000001: decode_seg = {1'b1, 4'd0};
            7'b1001111: decode_seg = {1'b1, 4'd1};
            7'b0010010: decode_seg = {1'b1, 4'd2};
            7'b0000110: decode_seg = {1'b1, 4'd3};
            7'b1001100: decode_seg = {1'b1, 4'd4};
            7'b0100100: decode_seg = {1'b1, 4'd5};
            7'b0100000: decode_seg = {1'b1, 4'd6};
            7'b0001111: decode_seg = {1'b1, 4'd7};
            7'b0000000: decode_seg = {1'b1, 4'd8};
            7'b0000100: decode_seg = {1'b1, 4'd9};
            default:    decode_seg = {1'b0, 4'd0};
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [6:0]       seg_q, seg_d;
    logic [6:0]       acc_pat_q, acc_pat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       digit_q, digit_d;
    logic             digit_valid_q, digit_valid_d;
    logic             blank_q, blank_d;
    logic             invalid_q, invalid_d;
    logic             seq_err_q, seq_err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [4:0]       dec_s;
    logic [3:0]       next_digit_s;
    logic             accept_s;

    // Sampling, acceptance, classification and error accounting.
    always_comb begin
        seg_d         = bus.segment;
        state_d       = state_q;
        acc_pat_d     = acc_pat_q;
        digit_d       = digit_q;
        blank_d       = blank_q;
        digit_valid_d = 1'b0;
        invalid_d     = 1'b0;
        seq_err_d     = 1'b0;
        err_count_d   = err_count_q;
        dec_s         = decode_seg(seg_q);
        next_digit_s  = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;

        if (bus.segment != seg_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // seg_q has been held for STABLE_CYCLES samples once cnt_q reaches CNT_ACCEPT.
        accept_s = (cnt_q >= CNT_ACCEPT) && (seg_q != acc_pat_q);

        if (accept_s) begin
            acc_pat_d = seg_q;
            if (dec_s[4]) begin
                digit_d       = dec_s[3:0];
                digit_valid_d = 1'b1;
                blank_d       = 1'b0;
                state_d       = TRACK;
                if ((state_q == TRACK) && (dec_s[3:0] != next_digit_s)) begin
                    seq_err_d = 1'b1;
                end else begin
                    seq_err_d = 1'b0;
                end
            end else if (seg_q == PAT_BLANK) begin
                blank_d = 1'b1;
                state_d = IDLE;
            end else begin
                invalid_d = 1'b1;
                blank_d   = 1'b0;
                state_d   = IDLE;
            end
        end else begin
            acc_pat_d = acc_pat_q;
        end

        if ((invalid_d || seq_err_d) && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_W'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            seg_q         <= PAT_BLANK;
            acc_pat_q     <= PAT_BLANK;
            cnt_q         <= {CNT_W{1'b0}};
            digit_q       <= 4'd0;
            digit_valid_q <= 1'b0;
            blank_q       <= 1'b1;
            invalid_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            err_count_q   <= {ERR_W{1'b0}};
        end else begin
            state_q       <= state_d;
            seg_q         <= seg_d;
            acc_pat_q     <= acc_pat_d;
            cnt_q         <= cnt_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            blank_q       <= blank_d;
            invalid_q     <= invalid_d;
            seq_err_q     <= seq_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.blank       = blank_q;
    assign bus.invalid     = invalid_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.err_count   = err_count_q;
endmodule

// File: tb/tb_segment_decoder.sv
// Directed self-checking bench for segment_decoder with hand-computed expectations.
module tb_segment_decoder;
    localparam int S     = 4;
    localparam int ERR_W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   exp_err;
    logic [6:0] seg_tab [10];

    segment_if #(.ERR_W(ERR_W)) bus ();

    segment_decoder #(.STABLE_CYCLES(S), .ERR_W(ERR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive pat for n cycles; the acceptance result is due after the (S+1)-th edge.
    task automatic hold(input string tag, input logic [6:0] pat, input int n,
                        input logic e_dv, input logic e_inv, input logic e_seq,
                        input logic [3:0] e_dig);
        logic extra;
        extra = 1'b0;
        bus.segment = pat;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (i == S + 1) begin
                check_eq({tag, "_dv"},  {31'd0, bus.digit_valid}, {31'd0, e_dv});
                check_eq({tag, "_inv"}, {31'd0, bus.invalid},     {31'd0, e_inv});
                check_eq({tag, "_seq"}, {31'd0, bus.seq_err},     {31'd0, e_seq});
            end else begin
                extra = extra | bus.digit_valid | bus.invalid | bus.seq_err;
            end
        end
        check_eq({tag, "_quiet"}, {31'd0, extra}, 32'd0);
        check_eq({tag, "_digit"}, {28'd0, bus.digit}, {28'd0, e_dig});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
        seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0000100;

        rst = 1'b1;
        bus.segment = 7'b1111111;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_digit", {28'd0, bus.digit}, 32'd0);
        check_eq("rst_blank", {31'd0, bus.blank}, 32'd1);
        check_eq("rst_err",   {24'd0, bus.err_count}, 32'd0);
        rst = 1'b0;

        // Idle blank bus produces nothing.
        hold("idle", 7'b1111111, 20, 1'b0, 1'b0, 1'b0, 4'd0);
        check_eq("idle_blank", {31'd0, bus.blank}, 32'd1);
        check_eq("idle_err",   {24'd0, bus.err_count}, 32'd0);

        // Counting sequence 0..9,0 including the wrap.
        for (int d = 0; d <= 10; d++) begin
            hold($sformatf("cnt%0d", d), seg_tab[d % 10], 10, 1'b1, 1'b0, 1'b0, 4'(d % 10));
            check_eq("cnt_blank", {31'd0, bus.blank}, 32'd0);
        end
        check_eq("cnt_err", {24'd0, bus.err_count}, 32'd0);

        // Walk to 3, glitch to 5 briefly, then really move to 5.
        hold("to1", seg_tab[1], 10, 1'b1, 1'b0, 1'b0, 4'd1);
        hold("to2", seg_tab[2], 10, 1'b1, 1'b0, 1'b0, 4'd2);
        hold("to3", seg_tab[3], 10, 1'b1, 1'b0, 1'b0, 4'd3);
        hold("glitch5", seg_tab[5], 3, 1'b0, 1'b0, 1'b0, 4'd3);
        hold("back3", seg_tab[3], 10, 1'b0, 1'b0, 1'b0, 4'd3);
        hold("jump5", seg_tab[5], 10, 1'b1, 1'b0, 1'b1, 4'd5);
        check_eq("jump_err", {24'd0, bus.err_count}, 32'd1);

        // Blank resets tracking; invalid code counts and drops back to IDLE.
        hold("blank", 7'b1111111, 10, 1'b0, 1'b0, 1'b0, 4'd5);
        check_eq("blank_lvl", {31'd0, bus.blank}, 32'd1);
        hold("idle2", seg_tab[2], 10, 1'b1, 1'b0, 1'b0, 4'd2);
        hold("bad", 7'b1111110, 10, 1'b0, 1'b1, 1'b0, 4'd2);
        check_eq("bad_err",   {24'd0, bus.err_count}, 32'd2);
        check_eq("bad_blank", {31'd0, bus.blank}, 32'd0);
        hold("idle7", seg_tab[7], 10, 1'b1, 1'b0, 1'b0, 4'd7);
        check_eq("idle7_err", {24'd0, bus.err_count}, 32'd2);

        // Alternate 2/5: every acceptance is a sequence error; counter must saturate.
        exp_err = 2;
        for (int i = 0; i < 300; i++) begin
            bus.segment = (i % 2 == 0) ? seg_tab[2] : seg_tab[5];
            repeat (S + 1) @(posedge clk);
            #1;
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            if (i == 99) check_eq("sat_mid", {24'd0, bus.err_count}, 32'(exp_err));
        end
        check_eq("sat_full",  {24'd0, bus.err_count}, 32'd255);
        check_eq("sat_digit", {28'd0, bus.digit}, 32'd5);
        hold("sat_more", seg_tab[2], S + 2, 1'b1, 1'b0, 1'b1, 4'd2);
        check_eq("sat_hold", {24'd0, bus.err_count}, 32'd255);

        // Reset between edges while 3 is two samples stable.
        bus.segment = seg_tab[3];
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_digit", {28'd0, bus.digit}, 32'd0);
        check_eq("arst_blank", {31'd0, bus.blank}, 32'd1);
        check_eq("arst_err",   {24'd0, bus.err_count}, 32'd0);
        check_eq("arst_dv",    {31'd0, bus.digit_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold("post_rst", seg_tab[3], 10, 1'b1, 1'b0, 1'b0, 4'd3);
        check_eq("post_err", {24'd0, bus.err_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
